// File: rtl/l2_way_ctrl.sv
// l2_way_ctrl: tag/valid store and victim selection for one 16-way L2 set, feeding the TimeStamp LRU tracker.
// Response 2 cycles after accept (hit or miss); a miss holds until fill_done; one request in flight, req_ready low while busy.
module l2_way_ctrl #(
  parameter int TAG_W = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  input  logic [TAG_W-1:0] req_tag,
  output logic             req_ready,
  output logic             resp_valid,
  output logic             resp_hit,
  output logic [3:0]       resp_way,
  output logic             evict_valid,
  output logic [TAG_W-1:0] evict_tag,
  input  logic             fill_done,
  input  logic             inv_all,
  input  logic [3:0]       oldest_stamp,
  output logic             lru_en,
  output logic [3:0]       lru_access
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOOKUP    = 2'd1;
  localparam logic [1:0] MISS_WAIT = 2'd2;
  localparam logic [1:0] UPDATE    = 2'd3;

  logic [1:0]       state;
  logic [TAG_W-1:0] tags [16];
  logic [15:0]      valid;
  logic [TAG_W-1:0] cur_tag;
  logic [3:0]       cur_way;

  logic [15:0]      match;
  logic             hit;
  logic [3:0]       hit_way;
  logic             any_free;
  logic [3:0]       free_way;
  logic [3:0]       victim;

  assign req_ready = (state == IDLE) && !inv_all;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      match[i] = valid[i] && (tags[i] == cur_tag);
    end
  end

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit     = |match;
    hit_way = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (match[i]) hit_way = 4'(i);
    end
  end

  always_comb begin
    any_free = ~&valid;
    free_way = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (!valid[i]) free_way = 4'(i);
    end
    victim = any_free ? free_way : oldest_stamp;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      valid       <= '0;
      cur_tag     <= '0;
      cur_way     <= '0;
      resp_valid  <= 1'b0;
      resp_hit    <= 1'b0;
      resp_way    <= '0;
      evict_valid <= 1'b0;
      evict_tag   <= '0;
      lru_en      <= 1'b0;
      lru_access  <= '0;
    end else begin
      resp_valid <= 1'b0;
      lru_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (inv_all) begin
            valid <= '0;
          end else if (req_valid) begin
            cur_tag <= req_tag;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          resp_valid <= 1'b1;
          resp_hit   <= hit;
          if (hit) begin
            cur_way     <= hit_way;
            resp_way    <= hit_way;
            evict_valid <= 1'b0;
            lru_en      <= 1'b1;
            lru_access  <= hit_way;
            state       <= UPDATE;
          end else begin
            cur_way     <= victim;
            resp_way    <= victim;
            evict_valid <= valid[victim];
            evict_tag   <= tags[victim];
            state       <= MISS_WAIT;
          end
        end
        MISS_WAIT: begin
          if (fill_done) begin
            valid[cur_way] <= 1'b1;
            lru_en         <= 1'b1;
            lru_access     <= cur_way;
            state          <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag array has no reset; valid gates every use of it.
  always_ff @(posedge clk) begin
    if (!reset && (state == MISS_WAIT) && fill_done) begin
      tags[cur_way] <= cur_tag;
    end
  end

endmodule

// File: tb/tb_l2_way_ctrl.sv
// Bench for l2_way_ctrl: directed scenarios then randomized requests against a set-level tag/valid model.
module tb_l2_way_ctrl;

  localparam int TW = 20;

  logic          clk;
  logic          reset;
  logic          req_valid;
  logic [TW-1:0] req_tag;
  logic          req_ready;
  logic          resp_valid;
  logic          resp_hit;
  logic [3:0]    resp_way;
  logic          evict_valid;
  logic [TW-1:0] evict_tag;
  logic          fill_done;
  logic          inv_all;
  logic [3:0]    oldest_stamp;
  logic          lru_en;
  logic [3:0]    lru_access;

  int total;
  int passed;

  logic [TW-1:0] mtag [16];
  bit            mvalid [16];

  l2_way_ctrl #(.TAG_W(TW)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_tag      (req_tag),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_way     (resp_way),
    .evict_valid  (evict_valid),
    .evict_tag    (evict_tag),
    .fill_done    (fill_done),
    .inv_all      (inv_all),
    .oldest_stamp (oldest_stamp),
    .lru_en       (lru_en),
    .lru_access   (lru_access)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) mvalid[i] = 1'b0;
  endtask

  // Set semantics: lowest valid matching way hits; else lowest empty way; else the LRU-reported way.
  function automatic void predict(input logic [TW-1:0] t, input logic [3:0] old,
                                  output bit h, output logic [3:0] w,
                                  output bit ev, output logic [TW-1:0] et);
    int found;
    int free;
    found = -1;
    free  = -1;
    h  = 1'b0;
    w  = old;
    ev = 1'b0;
    et = '0;
    for (int i = 0; i < 16; i++)
      if (mvalid[i] && mtag[i] == t && found < 0) found = i;
    if (found >= 0) begin
      h = 1'b1;
      w = 4'(found);
      return;
    end
    for (int i = 0; i < 16; i++)
      if (!mvalid[i] && free < 0) free = i;
    if (free >= 0) begin
      w = 4'(free);
    end else begin
      w  = old;
      ev = 1'b1;
      et = mtag[old];
    end
  endfunction

  // One full request: accept cycle T, then checks every cycle until back in IDLE.
  task automatic do_req(input logic [TW-1:0] t, input logic [3:0] old, input int dly,
                        input bit keep, input bit noise);
    bit            ph;
    logic [3:0]    pw;
    bit            pe;
    logic [TW-1:0] pt;
    predict(t, old, ph, pw, pe, pt);

    @(negedge clk);
    req_valid = 1'b1; req_tag = t; oldest_stamp = old; inv_all = 1'b0;
    fill_done = noise ? 1'($urandom) : 1'b0;
    #1 chk("accept_ready", 32'(req_ready), 1);

    @(negedge clk);  // LOOKUP
    if (!keep) begin
      req_valid = 1'b0;
      req_tag   = TW'($urandom);
    end
    inv_all   = noise ? 1'($urandom) : 1'b0;
    fill_done = noise ? 1'($urandom) : 1'b0;
    #1;
    chk("lookup_resp_valid", 32'(resp_valid), 0);
    chk("lookup_lru_en", 32'(lru_en), 0);
    chk("lookup_ready", 32'(req_ready), 0);

    @(negedge clk);  // response cycle
    oldest_stamp = noise ? 4'($urandom) : old;
    inv_all      = noise ? 1'($urandom) : 1'b0;
    fill_done    = (!ph && dly == 0);
    #1;
    chk("resp_valid", 32'(resp_valid), 1);
    chk("resp_hit", 32'(resp_hit), 32'(ph));
    chk("resp_way", 32'(resp_way), 32'(pw));
    chk("evict_valid", 32'(evict_valid), 32'(pe));
    if (pe) chk("evict_tag", 32'(evict_tag), 32'(pt));
    chk("resp_lru_en", 32'(lru_en), 32'(ph));
    if (ph) chk("hit_lru_access", 32'(lru_access), 32'(pw));
    chk("resp_ready", 32'(req_ready), 0);

    if (ph) begin
      @(negedge clk);
      req_valid = 1'b0; inv_all = 1'b0;
      fill_done = noise ? 1'($urandom) : 1'b0;
      #1;
      chk("hit_done_resp_valid", 32'(resp_valid), 0);
      chk("hit_done_lru_en", 32'(lru_en), 0);
      chk("hit_done_ready", 32'(req_ready), 1);
    end else begin
      for (int d = 1; d <= dly; d++) begin
        @(negedge clk);
        fill_done = (d == dly);
        inv_all   = noise ? 1'($urandom) : 1'b0;
        #1;
        chk("wait_resp_valid", 32'(resp_valid), 0);
        chk("wait_lru_en", 32'(lru_en), 0);
        chk("wait_ready", 32'(req_ready), 0);
      end
      @(negedge clk);  // one cycle after fill accepted
      fill_done = noise ? 1'($urandom) : 1'b0;
      inv_all   = noise ? 1'($urandom) : 1'b0;
      #1;
      chk("fill_lru_en", 32'(lru_en), 1);
      chk("fill_lru_access", 32'(lru_access), 32'(pw));
      chk("fill_resp_valid", 32'(resp_valid), 0);
      chk("fill_ready", 32'(req_ready), 0);
      mtag[pw]   = t;
      mvalid[pw] = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; inv_all = 1'b0;
      fill_done = noise ? 1'($urandom) : 1'b0;
      #1;
      chk("miss_done_lru_en", 32'(lru_en), 0);
      chk("miss_done_resp_valid", 32'(resp_valid), 0);
      chk("miss_done_ready", 32'(req_ready), 1);
    end
    fill_done = 1'b0;
  endtask

  task automatic do_inv(input bit with_req, input logic [TW-1:0] t);
    @(negedge clk);
    inv_all = 1'b1; req_valid = with_req; req_tag = t; fill_done = 1'b0;
    #1 chk("inv_ready", 32'(req_ready), 0);
    model_clear();
    @(negedge clk);
    inv_all = 1'b0; req_valid = 1'b0;
    #1;
    chk("inv_after_ready", 32'(req_ready), 1);
    chk("inv_after_resp_valid", 32'(resp_valid), 0);
    chk("inv_after_lru_en", 32'(lru_en), 0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1; req_valid = 1'b0; req_tag = '0; fill_done = 1'b0;
    inv_all = 1'b0; oldest_stamp = '0;
    model_clear();
    for (int i = 0; i < 16; i++) mtag[i] = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_hit", 32'(resp_hit), 0);
    chk("rst_resp_way", 32'(resp_way), 0);
    chk("rst_evict_valid", 32'(evict_valid), 0);
    chk("rst_evict_tag", 32'(evict_tag), 0);
    chk("rst_lru_en", 32'(lru_en), 0);
    chk("rst_lru_access", 32'(lru_access), 0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_ready", 32'(req_ready), 1);

    // First miss into an empty set, fill in the first wait cycle.
    do_req(20'h00123, 4'd0, 0, 1'b0, 1'b0);

    // Allocate ways in order, then hit way 5.
    do_inv(1'b0, '0);
    for (int i = 0; i < 16; i++) do_req(TW'(32'h10 + i), 4'($urandom), i % 3, 1'b0, 1'b0);
    do_req(20'h00015, 4'd0, 0, 1'b0, 1'b0);

    // Full set: victim comes from oldest_stamp.
    do_req(20'h00999, 4'd7, 2, 1'b0, 1'b0);
    do_req(20'h00999, 4'd3, 0, 1'b0, 1'b0);
    do_req(20'h00017, 4'd3, 1, 1'b0, 1'b0);

    // Reset while waiting for a fill.
    @(negedge clk);
    req_valid = 1'b1; req_tag = 20'h00777; oldest_stamp = 4'd9; inv_all = 1'b0; fill_done = 1'b0;
    #1 chk("abort_accept", 32'(req_ready), 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #1 chk("abort_resp_valid", 32'(resp_valid), 1);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("abort_wait_ready", 32'(req_ready), 0);
    @(negedge clk);
    reset = 1'b0; fill_done = 1'b1;
    #1;
    chk("abort_resp_valid_0", 32'(resp_valid), 0);
    chk("abort_resp_hit", 32'(resp_hit), 0);
    chk("abort_resp_way", 32'(resp_way), 0);
    chk("abort_evict_valid", 32'(evict_valid), 0);
    chk("abort_evict_tag", 32'(evict_tag), 0);
    chk("abort_lru_en", 32'(lru_en), 0);
    chk("abort_lru_access", 32'(lru_access), 0);
    chk("abort_ready", 32'(req_ready), 1);
    model_clear();
    @(negedge clk);
    fill_done = 1'b0;
    #1;
    chk("abort_lru_en_next", 32'(lru_en), 0);
    chk("abort_ready_next", 32'(req_ready), 1);
    do_req(20'h00777, 4'($urandom), 1, 1'b0, 1'b0);

    // inv_all blocks a same-cycle request; it is taken the next cycle.
    do_inv(1'b1, 20'h00055);
    do_req(20'h00055, 4'd4, 0, 1'b0, 1'b0);

    // Long fill with the requester still asserting req_valid.
    do_req(20'h00ABC, 4'd2, 10, 1'b1, 1'b0);

    // Randomized traffic over a small tag pool so the set fills and evicts.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 11) == 0)
        do_inv(1'($urandom), TW'($urandom));
      do_req(TW'(32'h100 + $urandom_range(0, 23)), 4'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
